// File: rtl/dmem_master.sv
// Data-memory initiator: one load or store at a time onto a word-addressed,
// byte-strobed synchronous memory port, with lane alignment and load extension.
module dmem_master #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        rready,
  output logic [29:0] raddr,
  input  logic [31:0] rdata,
  output logic        wready,
  output logic [29:0] waddr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] WAIT_LOAD = (LAT >= 2) ? 2'(LAT - 2) : 2'd0;

  logic [1:0]  state;
  logic [1:0]  cnt;
  logic        we_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic        err_p0;
  logic        accept;
  logic        in_issue;
  logic        in_resp;

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    access_err = 1'b0;
      2'd1:    access_err = lo[0];
      2'd2:    access_err = |lo;
      default: access_err = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    lane_strb = 4'b0001 << lo;
      2'd1:    lane_strb = 4'b0011 << lo;
      default: lane_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    lane_data = {4{d[7:0]}};
      2'd1:    lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                              input logic [1:0] lo, input logic [31:0] d);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = d >> {lo, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'd0: begin
        if (uns) load_extend = {24'd0, sh[7:0]};
        else     load_extend = 32'(b);
      end
      2'd1: begin
        if (uns) load_extend = {16'd0, sh[15:0]};
        else     load_extend = 32'(h);
      end
      default: load_extend = sh;
    endcase
  endfunction

  // Readiness is masked by reset so every output reads 0 while rst is high.
  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign in_issue  = (state == S_ISSUE);
  assign in_resp   = (state == S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        S_IDLE: if (accept) state <= S_ISSUE;
        S_ISSUE: begin
          if (err_p0 || we_p0) begin
            state <= S_IDLE;
          end else if (LAT == 1) begin
            state <= S_RESP;
          end else begin
            state <= S_WAIT;
            cnt   <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (cnt == 2'd0) state <= S_RESP;
          else             cnt   <= cnt - 2'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request capture stage
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      uns_p0   <= req_unsigned;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      err_p0   <= access_err(req_size, req_addr[1:0]);
    end
  end

  // Memory issue and response stage
  always_comb begin
    rready     = in_issue && !err_p0 && !we_p0;
    wready     = in_issue && !err_p0 && we_p0;
    raddr      = rready ? addr_p0[31:2] : 30'd0;
    waddr      = wready ? addr_p0[31:2] : 30'd0;
    wdata      = wready ? lane_data(size_p0, wdata_p0) : 32'd0;
    wstrb      = wready ? lane_strb(size_p0, addr_p0[1:0]) : 4'd0;
    resp_valid = (in_issue && (err_p0 || we_p0)) || in_resp;
    resp_err   = in_issue && err_p0;
    resp_rdata = in_resp ? load_extend(size_p0, uns_p0, addr_p0[1:0], rdata) : 32'd0;
  end

endmodule

// File: tb/tb_dmem_master.sv
// Directed bench for dmem_master: two instances (LAT=1 and LAT=3) sharing one
// request stream and a byte-strobed memory model.
module tb_dmem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready1, resp_valid1, resp_err1, rready1, wready1;
  logic [31:0] resp_rdata1, rdata1, wdata1;
  logic [29:0] raddr1, waddr1;
  logic [3:0]  wstrb1;

  logic        req_ready3, resp_valid3, resp_err3, rready3, wready3;
  logic [31:0] resp_rdata3, rdata3, wdata3;
  logic [29:0] raddr3, waddr3;
  logic [3:0]  wstrb3;

  logic [31:0] mem [0:255];
  logic [31:0] pipe0, pipe1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_master #(.LAT(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1), .rready(rready1),
    .raddr(raddr1), .rdata(rdata1), .wready(wready1), .waddr(waddr1),
    .wdata(wdata1), .wstrb(wstrb1)
  );

  dmem_master #(.LAT(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid3),
    .resp_rdata(resp_rdata3), .resp_err(resp_err3), .rready(rready3),
    .raddr(raddr3), .rdata(rdata3), .wready(wready3), .waddr(waddr3),
    .wdata(wdata3), .wstrb(wstrb3)
  );

  // Memory: writes from the LAT=1 port, 1-cycle read for u1, 3-cycle read for u3.
  always @(posedge clk) begin
    if (wready1) begin
      for (int b = 0; b < 4; b++)
        if (wstrb1[b]) mem[waddr1[7:0]][8*b +: 8] <= wdata1[8*b +: 8];
    end
    if (rready1) rdata1 <= mem[raddr1[7:0]];
    pipe0  <= mem[raddr3[7:0]];
    pipe1  <= pipe0;
    rdata3 <= pipe1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready1 && req_ready3) && n < 20) begin
      step();
      n++;
    end
    chk("idle_wait", {31'd0, req_ready1 && req_ready3}, 32'd1);
  endtask

  // Returns in the ISSUE cycle (accept edge + 1 ns).
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] data);
    wait_idle();
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = data;
    req_valid    = 1'b1;
    step();
    req_valid    = 1'b0;
  endtask

  logic [1:0]  esz  [3];
  logic        ewe  [3];
  logic [31:0] eadr [3];

  initial begin
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'hDEADBEEF;
    #2 rst = 1'b1;
    step(); step();
    chk("rst_req_ready", {31'd0, req_ready1}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid1 | resp_valid3}, 32'd0);
    chk("rst_rw_ready", {30'd0, rready1, wready1}, 32'd0);
    chk("rst_wstrb_waddr", {wstrb1, waddr1[27:0]}, 32'd0);
    chk("rst_resp_rdata", resp_rdata1, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, req_ready1}, 32'd1);
    step();
    req_valid = 1'b0;
    chk("sw_wready", {31'd0, wready1}, 32'd1);
    chk("sw_wstrb", {28'd0, wstrb1}, 32'hF);
    chk("sw_waddr", {2'd0, waddr1}, 32'h40);
    chk("sw_wdata", wdata1, 32'hDEADBEEF);
    chk("sw_resp", {30'd0, resp_valid1, resp_err1}, 32'd2);
    chk("sw_req_ready", {31'd0, req_ready1}, 32'd0);

    send(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    chk("lw_rready", {31'd0, rready1}, 32'd1);
    chk("lw_raddr", {2'd0, raddr1}, 32'h40);
    chk("lw_no_early_resp", {31'd0, resp_valid1}, 32'd0);
    step();
    chk("lw_resp_valid", {31'd0, resp_valid1}, 32'd1);
    chk("lw_rdata", resp_rdata1, 32'hDEADBEEF);
    step();
    chk("lw_pulse", {31'd0, resp_valid1}, 32'd0);

    send(1'b1, 2'd0, 1'b0, 32'h103, 32'hABCDEF80);
    chk("sb_wstrb", {28'd0, wstrb1}, 32'h8);
    chk("sb_wdata", wdata1, 32'h80808080);
    chk("sb_waddr", {2'd0, waddr1}, 32'h40);
    send(1'b0, 2'd0, 1'b0, 32'h103, 32'd0);
    step();
    chk("lb_rdata", resp_rdata1, 32'hFFFFFF80);
    send(1'b0, 2'd0, 1'b1, 32'h103, 32'd0);
    step();
    chk("lbu_rdata", resp_rdata1, 32'h00000080);

    send(1'b1, 2'd1, 1'b0, 32'h202, 32'h12348001);
    chk("sh_wstrb", {28'd0, wstrb1}, 32'hC);
    chk("sh_wdata", wdata1, 32'h80018001);
    chk("sh_waddr", {2'd0, waddr1}, 32'h80);
    send(1'b0, 2'd1, 1'b0, 32'h202, 32'd0);
    step();
    chk("lh_rdata", resp_rdata1, 32'hFFFF8001);
    send(1'b0, 2'd1, 1'b1, 32'h202, 32'd0);
    step();
    chk("lhu_rdata", resp_rdata1, 32'h00008001);

    ewe[0] = 1'b0; esz[0] = 2'd2; eadr[0] = 32'h101;
    ewe[1] = 1'b1; esz[1] = 2'd1; eadr[1] = 32'h3;
    ewe[2] = 1'b0; esz[2] = 2'd3; eadr[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      send(ewe[i], esz[i], 1'b0, eadr[i], 32'hFFFFFFFF);
      chk("err_resp", {30'd0, resp_valid1, resp_err1}, 32'd3);
      chk("err_rdata", resp_rdata1, 32'd0);
      chk("err_no_mem", {30'd0, rready1, wready1}, 32'd0);
      chk("err_wstrb", {28'd0, wstrb1}, 32'd0);
    end

    send(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    chk("lat3_rready", {31'd0, rready3}, 32'd1);
    step();
    chk("lat3_c2", {31'd0, resp_valid3}, 32'd0);
    step();
    chk("lat3_c3", {31'd0, resp_valid3}, 32'd0);
    step();
    chk("lat3_c4_valid", {31'd0, resp_valid3}, 32'd1);
    chk("lat3_c4_rdata", resp_rdata3, 32'h80ADBEEF);
    step();
    chk("lat3_pulse", {31'd0, resp_valid3}, 32'd0);

    send(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("abort_outputs", {29'd0, resp_valid3, rready3, req_ready3}, 32'd0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_resp", {31'd0, resp_valid3}, 32'd0);
    end

    send(1'b1, 2'd2, 1'b0, 32'h300, 32'd0);
    send(1'b1, 2'd2, 1'b0, 32'h300, 32'h12345678);
    chk("abort_st_issue", {31'd0, wready1}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_st_gated", {27'd0, wready1, wstrb1}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    send(1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
    step();
    chk("abort_st_unwritten", resp_rdata1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_master.md
# dmem_master

Data-memory initiator for the three-stage core. Accepts one load or store at a time from the execute/writeback stage and drives the word-addressed, byte-strobed synchronous memory port (`rready`/`raddr`, `wready`/`waddr`/`wdata`/`wstrb`, registered `rdata`). Aligns store data to byte lanes, extracts and sign- or zero-extends load data, and flags misaligned or illegal-size accesses. No memory access is issued for a flagged request.

## Interface
- `LAT`, default 1: memory read latency in cycles, from the `rready` cycle to the cycle `rdata` is valid. Legal range 1..4.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted on a cycle with `req_valid & req_ready`.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned` input 1: zero-extend loads (LBU/LHU); ignored for word and stores.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: misaligned or illegal size; qualified by `resp_valid`.
- `rready` output 1: memory read enable.
- `raddr` output 30 ([31:2]): read word address.
- `rdata` input 32: memory read data (registered in memory).
- `wready` output 1: memory write enable.
- `waddr` output 30 ([31:2]): write word address.
- `wdata` output 32: lane-replicated write data.
- `wstrb` output 4: byte write strobes.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1. On accept, latch all request fields into registers, compute `err`, and go to ISSUE.
- Alignment rules: a byte access is always legal. A half access requires `addr[0]`=0. A word access requires `addr[1:0]`=0. Size 3 sets `err`.
- ISSUE, err case: no `rready` and no `wready`. Assert `resp_valid`=1 and `resp_err`=1 with `resp_rdata`=0, then go to IDLE.
- ISSUE, store: assert `wready`=1 and `waddr`=`addr[31:2]`. Byte store: `wstrb`=0001<<`addr[1:0]` and `wdata`={4{wdata[7:0]}}. Half store: `wstrb`=0011<<`addr[1:0]` and `wdata`={2{wdata[15:0]}}. Word store: `wstrb`=1111. Assert `resp_valid`=1 in the same cycle, then go to IDLE.
- ISSUE, load: assert `rready`=1 and `raddr`=`addr[31:2]`. Go to RESP if `LAT`=1; otherwise go to WAIT with the counter loaded to `LAT`-2.
- WAIT: decrement the counter. When the counter reaches 0, go to RESP.
- RESP: assert `resp_valid`=1. `resp_rdata` is the lane selected by `addr[1:0]`, taken combinationally from `rdata`, then sign- or zero-extended per the latched size and unsigned flag. Go to IDLE.
- `rready` and `wready` are high only in ISSUE, and never both in the same cycle.
- `raddr`, `waddr`, `wdata` and `wstrb` are 0 outside ISSUE.
- `req_ready` is low in ISSUE, WAIT and RESP; requests presented then are held off, not dropped.

## Timing
- Reset: all outputs 0, state IDLE, counter 0. `req_ready` rises in the first cycle after `rst` deasserts.
- Reset mid-operation forces all outputs to 0 asynchronously.
  - A store caught in ISSUE is not written.
  - A pending load produces no `resp_valid`.
- Accept in cycle N puts ISSUE in N+1.
- Store and error latency: `resp_valid` in N+1. Back-to-back throughput is one request per 2 cycles.
- Load latency: `resp_valid` in N+1+`LAT`. Throughput is one load per `LAT`+2 cycles.
- A store accepted in N followed by a load to the same word returns the new data. The write completes at the end of N+1; the load's `rready` is in N+3 or later.
- `resp_valid` is always a single-cycle pulse, with no backpressure on the response.

## Test plan
- Reset with `req_valid`=1 held → all outputs 0 during reset; accept on the first cycle after release.
- Store word 0xDEADBEEF at 0x100, then load word 0x100 with `LAT`=1 → `wstrb`=1111, `waddr`=0x40; load `resp_valid` two cycles after accept with `resp_rdata`=0xDEADBEEF.
- Store byte 0x80 at 0x103, then LB and LBU at 0x103 → `wstrb`=1000, `wdata`=0x80808080; LB returns 0xFFFFFF80 and LBU returns 0x00000080.
- Store half 0x8001 at 0x202, then LH at 0x202 → `wstrb`=1100; LH returns 0xFFFF8001.
- LW at 0x101, SH at 0x3, and size 3 at 0x0 → `resp_err`=1 with `resp_rdata`=0, and `rready`/`wready` never asserted.
- `LAT`=3 load, with `rst` pulsed in WAIT on a second load → first `resp_valid` arrives exactly 4 cycles after accept; the aborted load never responds.
